// File: rtl/tp84_pll_speed_seq_if.sv
// Avalon-MM write-only management bus toward the PLL reconfiguration controller.
interface tp84_pll_speed_seq_if;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_write,
        output mgmt_address,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_write,
        input  mgmt_address,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );
endinterface

// File: rtl/tp84_pll_speed_seq.sv
// Switches the core PLL between native and underclocked rates by writing mode, fractional-K
// and start registers of the reconfig controller, then waits for relock and reports the speed.
module tp84_pll_speed_seq #(
    parameter logic [31:0] K_NATIVE     = 32'd3639383488,
    parameter logic [31:0] K_UNDER      = 32'd3262113561,
    parameter int          FILT_LEN     = 16,
    parameter int          UNLOCK_WAIT  = 1024,
    parameter int          LOCK_TIMEOUT = 1048576
) (
    input  logic                         clk_50m,
    input  logic                         reset,
    input  logic                         underclock_req,
    input  logic                         pll_locked,
    tp84_pll_speed_seq_if.master         mgmt,
    output logic                         busy,
    output logic                         underclock_act,
    output logic                         lock_err
);

    localparam int          FCW         = $clog2(FILT_LEN + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
    localparam logic [19:0] UNLOCK_LAST = 20'(UNLOCK_WAIT - 1);
    localparam logic [19:0] LOCK_LAST   = 20'(LOCK_TIMEOUT - 1);
    localparam logic [5:0]  ADDR_MODE   = 6'd0;
    localparam logic [5:0]  ADDR_FRAC   = 6'd7;
    localparam logic [5:0]  ADDR_START  = 6'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MODE,
        S_W_FRAC,
        S_W_START,
        S_WAIT_UNLOCK,
        S_WAIT_LOCK
    } state_t;

    logic           req_meta_q, req_s_q, lck_meta_q, lck_s_q;
    logic [FCW-1:0] filt_cnt_q;
    logic           req_f_q;

    state_t         state_q;
    logic           pend_q, tgt_q;
    logic [19:0]    tmr_q;
    logic           wr_q;
    logic [5:0]     addr_q;
    logic [31:0]    data_q;
    logic           busy_q, act_q, err_q;

    logic [19:0]    tmr_d;
    logic           start_d;
    logic [31:0]    frac_d;

    always_ff @(posedge clk_50m or negedge reset) begin
        if (!reset) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
            lck_meta_q <= 1'b0;
            lck_s_q    <= 1'b0;
        end else begin
            req_meta_q <= underclock_req;
            req_s_q    <= req_meta_q;
            lck_meta_q <= pll_locked;
            lck_s_q    <= lck_meta_q;
        end
    end

    // req_f follows req_s only after FILT_LEN consecutive samples disagreeing with it
    always_ff @(posedge clk_50m or negedge reset) begin
        if (!reset) begin
            filt_cnt_q <= '0;
            req_f_q    <= 1'b0;
        end else if (req_s_q == req_f_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FILT_LAST) begin
            req_f_q    <= req_s_q;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    assign tmr_d   = (tmr_q == 20'hFFFFF) ? tmr_q : tmr_q + 20'd1;
    assign start_d = pend_q || (req_f_q != act_q);
    assign frac_d  = tgt_q ? K_UNDER : K_NATIVE;

    always_ff @(posedge clk_50m or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b1;
            tgt_q   <= 1'b0;
            tmr_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            act_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        tgt_q   <= req_f_q;
                        pend_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        wr_q    <= 1'b1;
                        addr_q  <= ADDR_MODE;
                        data_q  <= '0;
                        tmr_q   <= '0;
                        state_q <= S_W_MODE;
                    end
                end
                S_W_MODE: begin
                    if (!mgmt.mgmt_waitrequest) begin
                        addr_q  <= ADDR_FRAC;
                        data_q  <= frac_d;
                        tmr_q   <= '0;
                        state_q <= S_W_FRAC;
                    end
                end
                S_W_FRAC: begin
                    if (!mgmt.mgmt_waitrequest) begin
                        addr_q  <= ADDR_START;
                        data_q  <= '0;
                        tmr_q   <= '0;
                        state_q <= S_W_START;
                    end
                end
                S_W_START: begin
                    if (!mgmt.mgmt_waitrequest) begin
                        wr_q    <= 1'b0;
                        addr_q  <= '0;
                        tmr_q   <= '0;
                        state_q <= S_WAIT_UNLOCK;
                    end
                end
                // A PLL that never visibly drops lock still gets a bounded wait here
                S_WAIT_UNLOCK: begin
                    if (!lck_s_q || tmr_q == UNLOCK_LAST) begin
                        tmr_q   <= '0;
                        state_q <= S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lck_s_q) begin
                        act_q   <= tgt_q;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        tmr_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (tmr_q == LOCK_LAST) begin
                        act_q   <= tgt_q;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        tmr_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    tmr_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mgmt.mgmt_write     = wr_q;
    assign mgmt.mgmt_address   = addr_q;
    assign mgmt.mgmt_writedata = data_q;
    assign busy                = busy_q;
    assign underclock_act      = act_q;
    assign lock_err            = err_q;

endmodule
